// File: rtl/sd_photo_pkg.sv
// Shared definitions for the SD photo reader: FSM encoding, BMP header length
// and the BGR888 -> RGB565 pixel packer.
package sd_photo_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_LATCH   = 3'd1;
    localparam logic [STATE_W-1:0] ST_START   = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_HI = 3'd3;
    localparam logic [STATE_W-1:0] ST_WAIT_LO = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE    = 3'd5;
    localparam logic [STATE_W-1:0] ST_HOLD    = 3'd6;

    // 54-byte BMP file + info header, counted in 16-bit SD words
    localparam logic [5:0] BMP_HDR_WORDS = 6'd27;

    function automatic logic [15:0] pack_rgb565(input logic [7:0] b,
                                                input logic [7:0] g,
                                                input logic [7:0] r);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

endpackage

// File: rtl/sd_photo_rd_ctrl_pack.sv
// Header skip, 3-phase BGR888 byte packer and per-frame pixel cap.
// Output strobe and data are registered one cycle after the accepted word.
module bgr888_to_rgb565_pack
    import sd_photo_pkg::*;
#(
    parameter logic [5:0] HDR_LEN = BMP_HDR_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        active,
    input  logic        val_en,
    input  logic [15:0] val_data,
    input  logic [23:0] pix_max,
    output logic        wr_en,
    output logic [15:0] wr_data
);

    logic [5:0]  word_cnt;
    logic [1:0]  phase;
    logic [23:0] pix_cnt;
    logic [7:0]  b_hold;
    logic [7:0]  g_hold;
    logic        accept;
    logic        in_hdr;
    logic        cap_hit;

    assign accept  = active && val_en;
    assign in_hdr  = (word_cnt < HDR_LEN);
    assign cap_hit = (pix_cnt == pix_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
            phase    <= '0;
            pix_cnt  <= '0;
            b_hold   <= '0;
            g_hold   <= '0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (clear) begin
                word_cnt <= '0;
                phase    <= '0;
                pix_cnt  <= '0;
            end else if (accept) begin
                if (in_hdr) begin
                    word_cnt <= word_cnt + 6'd1;
                end else begin
                    case (phase)
                        2'd0: begin
                            b_hold <= val_data[15:8];
                            g_hold <= val_data[7:0];
                            phase  <= 2'd1;
                        end
                        2'd1: begin
                            if (!cap_hit) begin
                                wr_en   <= 1'b1;
                                wr_data <= pack_rgb565(b_hold, g_hold, val_data[15:8]);
                                pix_cnt <= pix_cnt + 24'd1;
                            end
                            b_hold <= val_data[7:0];
                            phase  <= 2'd2;
                        end
                        default: begin
                            if (!cap_hit) begin
                                wr_en   <= 1'b1;
                                wr_data <= pack_rgb565(b_hold, val_data[15:8], val_data[7:0]);
                                pix_cnt <= pix_cnt + 24'd1;
                            end
                            phase <= 2'd0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/sd_photo_rd_ctrl.sv
// Sector-read sequencer: loads one BMP picture from SD into SDRAM as RGB565,
// alternating between two pictures with a hold time between frames.
//
// state   | meaning
// IDLE    | wait for SD card initialisation
// LATCH   | capture sector/pixel counts, pick picture base address
// START   | one-cycle single-sector read command
// WAIT_HI | wait for the SD controller to go busy
// WAIT_LO | wait for the sector read to finish, advance address
// DONE    | frame complete pulse, load hold timer
// HOLD    | hold timer down-count, then switch picture
module sd_photo_rd_ctrl
    import sd_photo_pkg::*;
#(
    parameter logic [31:0] PIC0_SEC_ADDR = 32'd16640,
    parameter logic [31:0] PIC1_SEC_ADDR = 32'd25280,
    parameter logic [31:0] HOLD_CYCLES   = 32'd50000000,
    parameter logic [5:0]  HDR_WORDS     = BMP_HDR_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sd_init_done,
    input  logic [15:0] sd_sec_num,
    input  logic [23:0] sdram_max_addr,
    input  logic        rd_busy,
    input  logic        rd_val_en,
    input  logic [15:0] rd_val_data,
    output logic        rd_start_en,
    output logic [31:0] rd_sec_addr,
    output logic        sdram_wr_en,
    output logic [15:0] sdram_wr_data,
    output logic        frame_done,
    output logic        cur_pic
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [15:0]        sec_num_q;
    logic [23:0]        pix_max_q;
    logic [15:0]        sec_cnt;
    logic [15:0]        sec_cnt_inc;
    logic [31:0]        hold_cnt;
    logic               pack_active;
    logic               pack_clear;

    assign sec_cnt_inc = sec_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!sd_init_done) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_LATCH;
                ST_LATCH:   state_nxt = (sd_sec_num == 16'd0) ? ST_DONE : ST_START;
                ST_START:   state_nxt = ST_WAIT_HI;
                ST_WAIT_HI: if (rd_busy) state_nxt = ST_WAIT_LO;
                ST_WAIT_LO: if (!rd_busy)
                                state_nxt = (sec_cnt_inc == sec_num_q) ? ST_DONE : ST_START;
                ST_DONE:    state_nxt = ST_HOLD;
                ST_HOLD:    if (hold_cnt == 32'd0) state_nxt = ST_LATCH;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_start_en = 1'b0;
        frame_done  = 1'b0;
        pack_active = 1'b0;
        pack_clear  = 1'b0;
        case (state)
            ST_LATCH:   pack_clear  = 1'b1;
            ST_START: begin
                rd_start_en = sd_init_done;
                pack_active = 1'b1;
            end
            ST_WAIT_HI: pack_active = 1'b1;
            ST_WAIT_LO: pack_active = 1'b1;
            ST_DONE:    frame_done  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_num_q   <= '0;
            pix_max_q   <= '0;
            sec_cnt     <= '0;
            hold_cnt    <= '0;
            rd_sec_addr <= '0;
            cur_pic     <= 1'b0;
        end else begin
            case (state)
                ST_LATCH: begin
                    sec_num_q   <= sd_sec_num;
                    pix_max_q   <= sdram_max_addr;
                    sec_cnt     <= '0;
                    rd_sec_addr <= cur_pic ? PIC1_SEC_ADDR : PIC0_SEC_ADDR;
                end
                ST_WAIT_LO: begin
                    if (!rd_busy) begin
                        sec_cnt     <= sec_cnt_inc;
                        rd_sec_addr <= rd_sec_addr + 32'd1;
                    end
                end
                ST_DONE: hold_cnt <= HOLD_CYCLES - 32'd1;
                ST_HOLD: begin
                    if (hold_cnt != 32'd0)
                        hold_cnt <= hold_cnt - 32'd1;
                    else if (sd_init_done)
                        cur_pic <= ~cur_pic;   // only when the next frame really starts
                end
                default: ;
            endcase
        end
    end

    bgr888_to_rgb565_pack #(
        .HDR_LEN (HDR_WORDS)
    ) u_pack (
        .clk      (clk),
        .rst      (rst),
        .clear    (pack_clear),
        .active   (pack_active),
        .val_en   (rd_val_en),
        .val_data (rd_val_data),
        .pix_max  (pix_max_q),
        .wr_en    (sdram_wr_en),
        .wr_data  (sdram_wr_data)
    );

endmodule

// File: tb/tb_sd_photo_rd_ctrl.sv
// Randomised bench for sd_photo_rd_ctrl with a byte-stream reference model
// of the BMP header strip, BGR888 -> RGB565 conversion and pixel cap.
module tb_sd_photo_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sd_init_done;
    logic [15:0] sd_sec_num;
    logic [23:0] sdram_max_addr;
    logic        rd_busy;
    logic        rd_val_en;
    logic [15:0] rd_val_data;
    logic        rd_start_en;
    logic [31:0] rd_sec_addr;
    logic        sdram_wr_en;
    logic [15:0] sdram_wr_data;
    logic        frame_done;
    logic        cur_pic;

    int tests = 0;
    int fails = 0;
    int n_start = 0;
    int n_done = 0;
    int n_wr = 0;

    logic [15:0] exp_q[$];
    logic [15:0] wr_log[$];
    logic [15:0] stage[$];

    int          m_words;
    int          m_pix;
    int          m_max;
    logic [7:0]  m_bytes[$];

    always #5 clk = ~clk;

    sd_photo_rd_ctrl #(
        .HOLD_CYCLES (32'd8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sd_init_done   (sd_init_done),
        .sd_sec_num     (sd_sec_num),
        .sdram_max_addr (sdram_max_addr),
        .rd_busy        (rd_busy),
        .rd_val_en      (rd_val_en),
        .rd_val_data    (rd_val_data),
        .rd_start_en    (rd_start_en),
        .rd_sec_addr    (rd_sec_addr),
        .sdram_wr_en    (sdram_wr_en),
        .sdram_wr_data  (sdram_wr_data),
        .frame_done     (frame_done),
        .cur_pic        (cur_pic)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_pix(input int b, input int g, input int r);
        return 16'(((r / 8) * 2048) + ((g / 4) * 32) + (b / 8));
    endfunction

    task automatic model_frame(input int max);
        m_words = 0;
        m_pix   = 0;
        m_max   = max;
        m_bytes.delete();
    endtask

    task automatic model_word(input logic [15:0] w);
        int b, g, r;
        if (m_words < 27) begin
            m_words++;
        end else begin
            m_bytes.push_back(w[15:8]);
            m_bytes.push_back(w[7:0]);
            while (m_bytes.size() >= 3) begin
                b = m_bytes.pop_front();
                g = m_bytes.pop_front();
                r = m_bytes.pop_front();
                if (m_pix < m_max) begin
                    exp_q.push_back(ref_pix(b, g, r));
                    m_pix++;
                end
            end
        end
    endtask

    // Monitor on the falling edge; the driver acts 1 time unit later.
    always @(negedge clk) begin
        if (rd_start_en) n_start++;
        if (frame_done)  n_done++;
        if (sdram_wr_en) begin
            n_wr++;
            wr_log.push_back(sdram_wr_data);
            if (exp_q.size() == 0) check("unexpected_wr", 32'd1, 32'd0);
            else                   check("wr_data", sdram_wr_data, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!rd_start_en && lat < 200);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!frame_done && lat < 200);
    endtask

    task automatic serve_sector(input int nwords, input bit abort);
        tick();
        repeat ($urandom_range(0, 2)) tick();
        rd_busy = 1'b1;
        for (int i = 0; i < nwords; i++) begin
            rd_val_en   = 1'b1;
            rd_val_data = (stage.size() != 0) ? stage.pop_front() : 16'($urandom);
            model_word(rd_val_data);
            tick();
            if ($urandom_range(0, 3) == 0) begin
                rd_val_en = 1'b0;
                tick();
            end
        end
        rd_val_en = 1'b0;
        repeat (2) tick();
        if (abort) begin
            sd_init_done = 1'b0;
            tick();
        end
        rd_busy = 1'b0;
    endtask

    task automatic do_sector(input string tag, input logic [31:0] addr, input int nwords);
        int lat;
        wait_start(lat);
        check({tag, "_start_seen"}, rd_start_en, 1'b1);
        check({tag, "_addr"}, rd_sec_addr, addr);
        serve_sector(nwords, 1'b0);
    endtask

    task automatic end_frame(input string tag);
        int lat;
        wait_done(lat);
        check({tag, "_done_lat"}, lat, 1);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic hold_junk(input int n);
        for (int i = 0; i < n; i++) begin
            rd_val_en   = 1'b1;
            rd_val_data = 16'($urandom);
            tick();
        end
        rd_val_en = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cs, cd, cw;

        rst = 1'b1; sd_init_done = 1'b0; rd_busy = 1'b0; rd_val_en = 1'b0;
        rd_val_data = '0; sd_sec_num = 16'd3; sdram_max_addr = 24'hFFFFFF;
        repeat (5) tick();
        check("rst_start_en", rd_start_en, 0);
        check("rst_sec_addr", rd_sec_addr, 0);
        check("rst_wr_en", sdram_wr_en, 0);
        check("rst_wr_data", sdram_wr_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_cur_pic", cur_pic, 0);

        rst = 1'b0;
        cs = n_start;
        repeat (10) tick();
        check("uninit_no_start", n_start - cs, 0);

        // Frame A: directed header + pixels, three sectors
        for (int i = 0; i < 27; i++) stage.push_back(16'hFFFF);
        stage.push_back(16'h1020); stage.push_back(16'h30F8); stage.push_back(16'hFC08);
        model_frame(24'hFFFFFF);
        wr_log.delete();
        cs = n_start; cd = n_done; cw = n_wr;
        sd_init_done = 1'b1;
        wait_start(lat);
        check("a_start_lat", lat, 2);
        check("a_addr0", rd_sec_addr, 32'd16640);
        check("a_pic", cur_pic, 0);
        serve_sector(30, 1'b0);
        sd_sec_num = 16'd5; sdram_max_addr = 24'd1;
        do_sector("a1", 32'd16641, 0);
        do_sector("a2", 32'd16642, 0);
        end_frame("a");
        check("a_starts", n_start - cs, 3);
        check("a_dones", n_done - cd, 1);
        check("a_wr_count", n_wr - cw, 2);
        if (wr_log.size() >= 2) begin
            check("a_px0", wr_log[0], 16'h3102);
            check("a_px1", wr_log[1], 16'h0FFF);
        end

        // Frame B: picture 1, pixel cap of 4
        sd_sec_num = 16'd2; sdram_max_addr = 24'd4;
        cs = n_start; cd = n_done; cw = n_wr;
        hold_junk(5);
        model_frame(4);
        wait_start(lat);
        check("b_start_lat", lat, 5);
        check("b_pic", cur_pic, 1);
        check("b_addr0", rd_sec_addr, 32'd25280);
        serve_sector(27 + 12, 1'b0);
        do_sector("b1", 32'd25281, 8);
        end_frame("b");
        check("b_wr_cap", n_wr - cw, 4);
        check("b_starts", n_start - cs, 2);
        check("b_dones", n_done - cd, 1);

        // Frame C: random data, aborted by init drop during WAIT_LO
        sd_sec_num = 16'd4; sdram_max_addr = 24'hFFFFFF;
        hold_junk(5);
        model_frame(24'hFFFFFF);
        wait_start(lat);
        check("c_start_lat", lat, 5);
        check("c_pic", cur_pic, 0);
        check("c_addr0", rd_sec_addr, 32'd16640);
        serve_sector($urandom_range(30, 60), 1'b0);
        do_sector("c1", 32'd16641, $urandom_range(5, 30));
        wait_start(lat);
        check("c2_addr", rd_sec_addr, 32'd16642);
        serve_sector($urandom_range(3, 10), 1'b1);
        cs = n_start; cd = n_done;
        repeat (30) tick();
        check("c_abort_starts", n_start - cs, 0);
        check("c_abort_dones", n_done - cd, 0);
        check("c_abort_pic", cur_pic, 0);
        check("c_abort_pending", exp_q.size(), 0);

        // Zero-sector frame: DONE straight from LATCH, hold still toggles picture
        sd_sec_num = 16'd0;
        cs = n_start;
        sd_init_done = 1'b1;
        wait_done(lat);
        check("z_done_lat", lat, 2);
        wait_done(lat);
        check("z_done_lat2", lat, 10);
        sd_init_done = 1'b0;
        tick();
        check("z_starts", n_start - cs, 0);
        check("z_pic", cur_pic, 1);

        // Mid-frame reset in WAIT_HI, then clean restart on picture 0
        sd_sec_num = 16'd3; sdram_max_addr = 24'hFFFFFF;
        model_frame(24'hFFFFFF);
        sd_init_done = 1'b1;
        wait_start(lat);
        check("r_start_lat", lat, 2);
        check("r_addr0", rd_sec_addr, 32'd25280);
        serve_sector(10, 1'b0);
        wait_start(lat);
        check("r_addr1", rd_sec_addr, 32'd25281);
        tick();
        rst = 1'b1;
        tick();
        check("r_start_en", rd_start_en, 0);
        check("r_sec_addr", rd_sec_addr, 0);
        check("r_wr_en", sdram_wr_en, 0);
        check("r_wr_data", sdram_wr_data, 0);
        check("r_frame_done", frame_done, 0);
        check("r_cur_pic", cur_pic, 0);
        rst = 1'b0;
        model_frame(24'hFFFFFF);
        cw = n_wr;
        wait_start(lat);
        check("r2_start_lat", lat, 2);
        check("r2_addr0", rd_sec_addr, 32'd16640);
        serve_sector(40, 1'b0);
        do_sector("r2_1", 32'd16641, 20);
        do_sector("r2_2", 32'd16642, 10);
        end_frame("r2");
        check("r2_wr_count", n_wr - cw, m_pix);

        sd_init_done = 1'b0;
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
